// File: rtl/simmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simmem_pkg
// Description : Shared types and sizing constants for the simulated-memory
//               write-response path.
//                 IDWidth                - AXI identifier width
//                 WriteRespBankCapacity  - number of response slots in the bank
//                 WriteRespBankAddrWidth - width of a slot index
//                 wresp_t                - write response beat (id + resp)
//                 slot_state_e           - lifecycle state of one bank slot
// Revision    : 1.0 - initial release
// ============================================================================
package simmem_pkg;

  localparam int unsigned IDWidth                = 4;
  localparam int unsigned WriteRespBankCapacity  = 4;
  localparam int unsigned WriteRespBankAddrWidth = $clog2(WriteRespBankCapacity);

  typedef struct packed {
    logic [IDWidth-1:0] id;
    logic [1:0]         resp;
  } wresp_t;

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_RESERVED = 2'd1,
    SLOT_FILLED   = 2'd2
  } slot_state_e;

endpackage
`default_nettype wire

// File: rtl/simmem_lzc_onehot.sv
`default_nettype none
// ============================================================================
// Module      : simmem_lzc_onehot
// Description : Lowest-index priority encoder with one-hot output.
//               Ports:
//                 i_vec    [WIDTH] - request vector
//                 o_onehot [WIDTH] - only the lowest set bit of i_vec, or 0
// Revision    : 1.0 - initial release
// ============================================================================
module simmem_lzc_onehot #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_onehot
);

  // x & -x keeps only the least significant set bit.
  assign o_onehot = i_vec & (~i_vec + WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/simmem_wresp_bank.sv
`default_nettype none
// ============================================================================
// Module      : simmem_wresp_bank
// Description : Write-response bank. Slots are reserved per write address,
//               filled by responses from real memory (oldest reservation with
//               a matching id first), and released toward the requester when
//               the delay calculator enables them, preserving per-id order.
//               Ports:
//                 clk_i, rst_ni                - clock, async active-low reset
//                 rsv_valid_i/rsv_id_i         - slot reservation request
//                 rsv_ready_o/rsv_iid_o        - free slot exists / its index
//                 in_valid_i/in_ready_o/in_data_i    - response from memory
//                 release_en_i [Capacity]      - per-slot release enables
//                 released_addr_onehot_o       - pulse for slot moved to output
//                 out_valid_o/out_ready_i/out_data_o - response to requester
// Revision    : 1.0 - initial release
// ============================================================================
module simmem_wresp_bank
  import simmem_pkg::*;
#(
  parameter int unsigned Capacity = WriteRespBankCapacity,
  parameter int unsigned IdWidth  = IDWidth
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,

  input  logic                              rsv_valid_i,
  input  logic [IdWidth-1:0]                rsv_id_i,
  output logic                              rsv_ready_o,
  output logic [WriteRespBankAddrWidth-1:0] rsv_iid_o,

  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  wresp_t                            in_data_i,

  input  logic [Capacity-1:0]               release_en_i,
  output logic [Capacity-1:0]               released_addr_onehot_o,

  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output wresp_t                            out_data_o
);

  // Per-slot storage
  slot_state_e        r_state     [Capacity];
  slot_state_e        w_state_nxt [Capacity];
  logic [IdWidth-1:0] r_id        [Capacity];
  wresp_t             r_data      [Capacity];
  logic [Capacity-1:0] r_rel;
  logic [Capacity-1:0] w_rel_nxt;
  // r_age[i][j] = 1 means slot i was reserved before slot j. Only entries
  // between two non-free slots carry meaning; a reservation rewrites the full
  // row and column of the granted slot, so stale entries never leak.
  logic [Capacity-1:0] r_age     [Capacity];
  logic [Capacity-1:0] w_age_nxt [Capacity];

  logic   r_out_valid;
  wresp_t r_out_data;

  logic [Capacity-1:0] w_free;
  logic [Capacity-1:0] w_busy;
  logic [Capacity-1:0] w_rsvd;
  logic [Capacity-1:0] w_filled;
  logic [Capacity-1:0] w_free_oh;
  logic [Capacity-1:0] w_rsv_oh;
  logic [Capacity-1:0] w_match;
  logic [Capacity-1:0] w_match_oldest;
  logic [Capacity-1:0] w_store_oh;
  logic [Capacity-1:0] w_elig;
  logic [Capacity-1:0] w_elig_oldest;
  logic [Capacity-1:0] w_pick_oh;
  logic                w_rsv_fire;
  logic                w_in_fire;
  logic                w_load;
  wresp_t              w_pick_data;
  logic [IdWidth-1:0]  w_in_id;

  assign w_in_id = IdWidth'(in_data_i.id);

  always_comb begin
    w_free   = '0;
    w_rsvd   = '0;
    w_filled = '0;
    for (int i = 0; i < Capacity; i++) begin
      w_free[i]   = (r_state[i] == SLOT_FREE);
      w_rsvd[i]   = (r_state[i] == SLOT_RESERVED);
      w_filled[i] = (r_state[i] == SLOT_FILLED);
    end
  end
  assign w_busy = ~w_free;

  // ---------------------------------------------------------------------------
  // Reservation: lowest free slot
  // ---------------------------------------------------------------------------
  simmem_lzc_onehot #(.WIDTH(Capacity)) u_free_pick (
    .i_vec    (w_free),
    .o_onehot (w_free_oh)
  );

  assign rsv_ready_o = |w_free;
  assign w_rsv_fire  = rsv_valid_i & rsv_ready_o;
  assign w_rsv_oh    = w_rsv_fire ? w_free_oh : '0;

  always_comb begin
    rsv_iid_o = '0;
    for (int i = 0; i < Capacity; i++) begin
      if (w_free_oh[i]) rsv_iid_o = rsv_iid_o | WriteRespBankAddrWidth'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Response store: oldest reserved slot whose id matches
  // ---------------------------------------------------------------------------
  always_comb begin
    w_match        = '0;
    w_match_oldest = '0;
    for (int i = 0; i < Capacity; i++) begin
      w_match[i] = w_rsvd[i] && (r_id[i] == w_in_id);
    end
    for (int i = 0; i < Capacity; i++) begin
      w_match_oldest[i] = w_match[i];
      for (int j = 0; j < Capacity; j++) begin
        if (w_match[j] && r_age[j][i]) w_match_oldest[i] = 1'b0;
      end
    end
  end

  assign in_ready_o = |w_match;
  assign w_in_fire  = in_valid_i & in_ready_o;
  assign w_store_oh = w_in_fire ? w_match_oldest : '0;

  // ---------------------------------------------------------------------------
  // Release selection. A slot being filled this cycle counts as filled, and a
  // release enable this cycle counts as a set flag, so both can bypass
  // straight into the output register.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_elig        = '0;
    w_elig_oldest = '0;
    for (int i = 0; i < Capacity; i++) begin
      w_elig[i] = (w_filled[i] | w_store_oh[i]) & (r_rel[i] | release_en_i[i]);
      // Keep per-id ordering: an older live slot with the same id blocks.
      for (int j = 0; j < Capacity; j++) begin
        if (w_busy[j] && r_age[j][i] && (r_id[j] == r_id[i])) w_elig[i] = 1'b0;
      end
    end
    for (int i = 0; i < Capacity; i++) begin
      w_elig_oldest[i] = w_elig[i];
      for (int j = 0; j < Capacity; j++) begin
        if (w_elig[j] && r_age[j][i]) w_elig_oldest[i] = 1'b0;
      end
    end
  end

  // Guarantees a single pick even if the age order were ever inconsistent.
  simmem_lzc_onehot #(.WIDTH(Capacity)) u_release_pick (
    .i_vec    (w_elig_oldest),
    .o_onehot (w_pick_oh)
  );

  assign w_load                 = (~r_out_valid | out_ready_i) & (|w_pick_oh);
  assign released_addr_onehot_o = w_load ? w_pick_oh : '0;

  always_comb begin
    w_pick_data = '0;
    for (int i = 0; i < Capacity; i++) begin
      if (w_pick_oh[i]) w_pick_data = w_store_oh[i] ? in_data_i : r_data[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Next slot state, release flags and age matrix
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rel_nxt = r_rel;
    for (int i = 0; i < Capacity; i++) begin
      w_state_nxt[i] = r_state[i];
      if (released_addr_onehot_o[i]) begin
        w_state_nxt[i] = SLOT_FREE;
        w_rel_nxt[i]   = 1'b0;
      end else begin
        if (w_busy[i] && release_en_i[i]) w_rel_nxt[i] = 1'b1;
        if (w_store_oh[i]) begin
          w_state_nxt[i] = SLOT_FILLED;
        end else if (w_rsv_oh[i]) begin
          w_state_nxt[i] = SLOT_RESERVED;
        end
      end

      // New slot: older than nothing, younger than every live slot.
      w_age_nxt[i] = w_rsv_oh[i] ? '0 : r_age[i];
      for (int j = 0; j < Capacity; j++) begin
        if (w_rsv_oh[j]) w_age_nxt[i][j] = w_busy[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Capacity; i++) begin
        r_state[i] <= SLOT_FREE;
        r_id[i]    <= '0;
        r_data[i]  <= '0;
        r_age[i]   <= '0;
      end
      r_rel       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      for (int i = 0; i < Capacity; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_age[i]   <= w_age_nxt[i];
        if (w_rsv_oh[i])   r_id[i]   <= rsv_id_i;
        if (w_store_oh[i]) r_data[i] <= in_data_i;
      end
      r_rel <= w_rel_nxt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pick_data;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_simmem_wresp_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_simmem_wresp_bank
// Description : Self-checking bench for simmem_wresp_bank: directed vector
//               table, hand-written corner sequences, and randomized traffic
//               against a sequence-number based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simmem_wresp_bank;
  import simmem_pkg::*;

  localparam int CAP = WriteRespBankCapacity;

  logic                              clk_i = 1'b0;
  logic                              rst_ni;
  logic                              rsv_valid_i;
  logic [IDWidth-1:0]                rsv_id_i;
  logic                              rsv_ready_o;
  logic [WriteRespBankAddrWidth-1:0] rsv_iid_o;
  logic                              in_valid_i;
  logic                              in_ready_o;
  wresp_t                            in_data_i;
  logic [CAP-1:0]                    release_en_i;
  logic [CAP-1:0]                    released_addr_onehot_o;
  logic                              out_valid_o;
  logic                              out_ready_i;
  wresp_t                            out_data_o;

  simmem_wresp_bank dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .rsv_valid_i            (rsv_valid_i),
    .rsv_id_i               (rsv_id_i),
    .rsv_ready_o            (rsv_ready_o),
    .rsv_iid_o              (rsv_iid_o),
    .in_valid_i             (in_valid_i),
    .in_ready_o             (in_ready_o),
    .in_data_i              (in_data_i),
    .release_en_i           (release_en_i),
    .released_addr_onehot_o (released_addr_onehot_o),
    .out_valid_o            (out_valid_o),
    .out_ready_i            (out_ready_i),
    .out_data_o             (out_data_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drv(input int rv, input int rid, input int iv, input int iid,
                     input int irsp, input int rel, input int ordy);
    rsv_valid_i    = rv[0];
    rsv_id_i       = IDWidth'(rid);
    in_valid_i     = iv[0];
    in_data_i.id   = IDWidth'(iid);
    in_data_i.resp = 2'(irsp);
    release_en_i   = CAP'(rel);
    out_ready_i    = ordy[0];
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: one row per cycle, continuous state across rows.
  // ---------------------------------------------------------------------------
  typedef struct {
    int rv, rid, iv, iid, irsp, rel, ordy;
    int e_rr, e_iid, e_ir, e_ov, e_pulse, e_oid, e_orsp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rv, int rid, int iv, int iid, int irsp, int rel,
                              int ordy, int e_rr, int e_iid, int e_ir, int e_ov,
                              int e_pulse, int e_oid, int e_orsp);
    vec_t v;
    v.rv = rv; v.rid = rid; v.iv = iv; v.iid = iid; v.irsp = irsp; v.rel = rel;
    v.ordy = ordy; v.e_rr = e_rr; v.e_iid = e_iid; v.e_ir = e_ir; v.e_ov = e_ov;
    v.e_pulse = e_pulse; v.e_oid = e_oid; v.e_orsp = e_orsp;
    return v;
  endfunction

  // Reference model state (sequence number = reservation age)
  int     m_state [CAP];   // 0 free, 1 reserved, 2 filled
  int     m_id    [CAP];
  int     m_rsp   [CAP];
  bit     m_rel   [CAP];
  longint m_seq   [CAP];
  longint seq_ctr;
  bit     m_ov;
  int     m_oid, m_orsp;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rv, rid, iv, iid, irsp, rel, ordy;
    int e_rr, e_iid, e_ir, e_pulse, store, pick;
    bit st_fire, load;

    // A: reserve id3, fill, release two cycles later
    vecs.push_back(mk(1,3, 0,0,0, 0,1, 1,0,0,0,0, 0,0));
    vecs.push_back(mk(0,0, 1,3,1, 0,1, 1,1,1,0,0, 0,0));
    vecs.push_back(mk(0,0, 0,0,0, 0,1, 1,1,0,0,0, 0,0));
    vecs.push_back(mk(0,0, 0,0,0, 1,1, 1,1,0,0,1, 0,0));
    vecs.push_back(mk(0,0, 0,0,0, 0,1, 1,0,0,1,0, 3,1));
    vecs.push_back(mk(0,0, 0,0,0, 0,1, 1,0,0,0,0, 0,0));
    // B: unreserved id7 held off, accepted the cycle after reservation
    vecs.push_back(mk(0,0, 1,7,2, 0,1, 1,0,0,0,0, 0,0));
    vecs.push_back(mk(1,7, 1,7,2, 0,1, 1,0,0,0,0, 0,0));
    vecs.push_back(mk(0,0, 1,7,2, 0,1, 1,1,1,0,0, 0,0));
    vecs.push_back(mk(0,0, 0,0,0, 1,1, 1,1,0,0,1, 0,0));
    vecs.push_back(mk(0,0, 0,0,0, 0,1, 1,0,0,1,0, 7,2));
    // C: two id5 slots, younger released first must wait for older
    vecs.push_back(mk(1,5, 0,0,0, 0,1, 1,0,0,0,0, 0,0));
    vecs.push_back(mk(1,5, 0,0,0, 0,1, 1,1,0,0,0, 0,0));
    vecs.push_back(mk(0,0, 1,5,0, 0,1, 1,2,1,0,0, 0,0));
    vecs.push_back(mk(0,0, 1,5,3, 0,1, 1,2,1,0,0, 0,0));
    vecs.push_back(mk(0,0, 0,0,0, 2,1, 1,2,0,0,0, 0,0));
    vecs.push_back(mk(0,0, 0,0,0, 0,1, 1,2,0,0,0, 0,0));
    vecs.push_back(mk(0,0, 0,0,0, 1,1, 1,2,0,0,1, 0,0));
    vecs.push_back(mk(0,0, 0,0,0, 0,1, 1,0,0,1,2, 5,0));
    vecs.push_back(mk(0,0, 0,0,0, 0,1, 1,0,0,1,0, 5,3));
    vecs.push_back(mk(0,0, 0,0,0, 0,1, 1,0,0,0,0, 0,0));
    // D: different ids, younger filled first goes out first
    vecs.push_back(mk(1,1, 0,0,0, 0,1, 1,0,0,0,0, 0,0));
    vecs.push_back(mk(1,2, 0,0,0, 0,1, 1,1,0,0,0, 0,0));
    vecs.push_back(mk(0,0, 0,0,0, 3,1, 1,2,0,0,0, 0,0));
    vecs.push_back(mk(0,0, 1,2,1, 0,1, 1,2,1,0,2, 0,0));
    vecs.push_back(mk(0,0, 1,1,2, 0,1, 1,1,1,1,1, 2,1));
    vecs.push_back(mk(0,0, 0,0,0, 0,1, 1,0,0,1,0, 1,2));
    vecs.push_back(mk(0,0, 0,0,0, 0,1, 1,0,0,0,0, 0,0));
    // E: store and release in the same cycle
    vecs.push_back(mk(1,4, 0,0,0, 0,1, 1,0,0,0,0, 0,0));
    vecs.push_back(mk(0,0, 1,4,3, 1,1, 1,1,1,0,1, 0,0));
    vecs.push_back(mk(0,0, 0,0,0, 0,1, 1,0,0,1,0, 4,3));
    vecs.push_back(mk(0,0, 0,0,0, 0,1, 1,0,0,0,0, 0,0));

    // ---------------- reset values ----------------
    rst_ni = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("rst_rsv_ready", int'(rsv_ready_o), 1);
    chk("rst_rsv_iid", int'(rsv_iid_o), 0);
    chk("rst_in_ready", int'(in_ready_o), 0);
    chk("rst_out_valid", int'(out_valid_o), 0);
    chk("rst_pulse", int'(released_addr_onehot_o), 0);
    chk("rst_out_data", int'(out_data_o), 0);
    tick();
    rst_ni = 1'b1;

    // ---------------- vector table ----------------
    for (int k = 0; k < vecs.size(); k++) begin
      drv(vecs[k].rv, vecs[k].rid, vecs[k].iv, vecs[k].iid, vecs[k].irsp,
          vecs[k].rel, vecs[k].ordy);
      @(negedge clk_i);
      chk($sformatf("vec%0d_rsv_ready", k), int'(rsv_ready_o), vecs[k].e_rr);
      if (vecs[k].e_rr != 0) chk($sformatf("vec%0d_rsv_iid", k), int'(rsv_iid_o), vecs[k].e_iid);
      chk($sformatf("vec%0d_in_ready", k), int'(in_ready_o), vecs[k].e_ir);
      chk($sformatf("vec%0d_out_valid", k), int'(out_valid_o), vecs[k].e_ov);
      chk($sformatf("vec%0d_pulse", k), int'(released_addr_onehot_o), vecs[k].e_pulse);
      if (vecs[k].e_ov != 0) begin
        chk($sformatf("vec%0d_out_id", k), int'(out_data_o.id), vecs[k].e_oid);
        chk($sformatf("vec%0d_out_resp", k), int'(out_data_o.resp), vecs[k].e_orsp);
      end
      tick();
    end

    // ---------------- full bank, stalled reservation ----------------
    do_reset();
    for (int s = 0; s < CAP; s++) begin
      drv(1, 8 + s, 0, 0, 0, 0, 1);
      @(negedge clk_i);
      chk("full_rsv_ready", int'(rsv_ready_o), 1);
      chk("full_rsv_iid", int'(rsv_iid_o), s);
      tick();
    end
    drv(1, 12, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    chk("full_stall_ready", int'(rsv_ready_o), 0);
    tick();
    for (int s = 0; s < CAP; s++) begin
      drv(1, 12, 1, 8 + s, s, 0, 1);
      @(negedge clk_i);
      chk("full_fill_in_ready", int'(in_ready_o), 1);
      chk("full_fill_rsv_ready", int'(rsv_ready_o), 0);
      tick();
    end
    drv(1, 12, 0, 0, 0, 4, 1);
    @(negedge clk_i);
    chk("full_rel_pulse", int'(released_addr_onehot_o), 4);
    chk("full_rel_rsv_ready", int'(rsv_ready_o), 0);
    tick();
    drv(1, 12, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    chk("full_freed_ready", int'(rsv_ready_o), 1);
    chk("full_freed_iid", int'(rsv_iid_o), 2);
    chk("full_freed_out_valid", int'(out_valid_o), 1);
    chk("full_freed_out_id", int'(out_data_o.id), 10);
    chk("full_freed_out_resp", int'(out_data_o.resp), 2);
    tick();
    drv(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    chk("full_regrant_ready", int'(rsv_ready_o), 0);
    tick();

    // ---------------- back-pressure and mid-sequence reset ----------------
    do_reset();
    drv(1, 1, 0, 0, 0, 0, 0); tick();
    drv(1, 2, 0, 0, 0, 0, 0); tick();
    drv(1, 3, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 1, 1, 1, 0, 0); tick();
    drv(0, 0, 1, 2, 2, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 3, 0);
    @(negedge clk_i);
    chk("bp_first_pulse", int'(released_addr_onehot_o), 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drv(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      chk("bp_out_valid", int'(out_valid_o), 1);
      chk("bp_out_id", int'(out_data_o.id), 1);
      chk("bp_out_resp", int'(out_data_o.resp), 1);
      chk("bp_no_pulse", int'(released_addr_onehot_o), 0);
      tick();
    end
    drv(0, 0, 1, 3, 0, 0, 0);
    @(negedge clk_i);
    chk("bp_pre_rst_in_ready", int'(in_ready_o), 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("mid_rst_rsv_ready", int'(rsv_ready_o), 1);
    chk("mid_rst_rsv_iid", int'(rsv_iid_o), 0);
    chk("mid_rst_in_ready", int'(in_ready_o), 0);
    chk("mid_rst_out_valid", int'(out_valid_o), 0);
    chk("mid_rst_pulse", int'(released_addr_onehot_o), 0);
    chk("mid_rst_out_data", int'(out_data_o), 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    drv(0, 0, 0, 0, 0, 15, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("post_rst_pulse", int'(released_addr_onehot_o), 0);
      chk("post_rst_out_valid", int'(out_valid_o), 0);
      tick();
    end

    // ---------------- randomized traffic vs. reference model ----------------
    do_reset();
    for (int i = 0; i < CAP; i++) begin
      m_state[i] = 0; m_id[i] = 0; m_rsp[i] = 0; m_rel[i] = 0; m_seq[i] = 0;
    end
    seq_ctr = 0; m_ov = 0; m_oid = 0; m_orsp = 0;

    for (int c = 0; c < 3000; c++) begin
      rv   = int'($urandom_range(0, 1));
      rid  = int'($urandom_range(0, 3));
      iv   = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) iid = m_id[$urandom_range(0, CAP - 1)];
      else                           iid = int'($urandom_range(0, 7));
      irsp = int'($urandom_range(0, 3));
      rel  = 0;
      for (int b = 0; b < CAP; b++) if ($urandom_range(0, 3) == 0) rel |= (1 << b);
      ordy = ($urandom_range(0, 3) != 0) ? 1 : 0;
      drv(rv, rid, iv, iid, irsp, rel, ordy);

      e_rr = 0; e_iid = 0;
      for (int i = CAP - 1; i >= 0; i--) if (m_state[i] == 0) begin e_rr = 1; e_iid = i; end
      store = -1;
      for (int i = 0; i < CAP; i++)
        if (m_state[i] == 1 && m_id[i] == iid && (store < 0 || m_seq[i] < m_seq[store])) store = i;
      e_ir    = (store >= 0) ? 1 : 0;
      st_fire = (iv != 0) && (store >= 0);
      pick = -1;
      for (int i = 0; i < CAP; i++) begin
        bit filled, relf, blk;
        filled = (m_state[i] == 2) || (st_fire && i == store);
        relf   = m_rel[i] || (rel[i] && m_state[i] != 0);
        blk    = 0;
        for (int j = 0; j < CAP; j++)
          if (m_state[j] != 0 && m_id[j] == m_id[i] && m_seq[j] < m_seq[i]) blk = 1;
        if (filled && relf && !blk && (pick < 0 || m_seq[i] < m_seq[pick])) pick = i;
      end
      load    = (!m_ov || ordy != 0) && (pick >= 0);
      e_pulse = load ? (1 << pick) : 0;

      @(negedge clk_i);
      chk("rnd_rsv_ready", int'(rsv_ready_o), e_rr);
      if (e_rr != 0) chk("rnd_rsv_iid", int'(rsv_iid_o), e_iid);
      chk("rnd_in_ready", int'(in_ready_o), e_ir);
      chk("rnd_out_valid", int'(out_valid_o), int'(m_ov));
      chk("rnd_pulse", int'(released_addr_onehot_o), e_pulse);
      if (m_ov) begin
        chk("rnd_out_id", int'(out_data_o.id), m_oid);
        chk("rnd_out_resp", int'(out_data_o.resp), m_orsp);
      end

      for (int i = 0; i < CAP; i++) if (m_state[i] != 0 && rel[i]) m_rel[i] = 1;
      if (st_fire) begin m_state[store] = 2; m_rsp[store] = irsp; end
      if (load) begin
        m_ov = 1; m_oid = m_id[pick]; m_orsp = m_rsp[pick];
        m_state[pick] = 0; m_rel[pick] = 0;
      end else if (ordy != 0) begin
        m_ov = 0;
      end
      if (rv != 0 && e_rr != 0) begin
        m_state[e_iid] = 1; m_id[e_iid] = rid; m_seq[e_iid] = seq_ctr; m_rel[e_iid] = 0;
        seq_ctr++;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simmem_wresp_bank.md
SIMMEM_WRESP_BANK -- requirements
Module: simmem_wresp_bank

Interface
REQ-001 Parameter Capacity, default simmem_pkg::WriteRespBankCapacity, number of response slots.
REQ-002 Parameter IdWidth, default simmem_pkg::IDWidth, AXI identifier width.
REQ-003 clk_i  in  1  clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 rsv_valid_i  in  1  requester asks for a slot for a write address with AXI id rsv_id_i.
REQ-006 rsv_id_i  in  IdWidth  AXI id of the write address being reserved.
REQ-007 rsv_ready_o  out  1  a free slot exists.
REQ-008 rsv_iid_o  out  WriteRespBankAddrWidth  slot index granted; meaningful when rsv_ready_o is 1; feeds the delay calculator's waddr_iid_i.
REQ-009 in_valid_i / in_ready_o / in_data_i (wresp_t)  in/out/in  1/1/$bits(wresp_t)  write response from real memory.
REQ-010 release_en_i  in  Capacity  one-hot-per-slot release enables from the delay calculator.
REQ-011 released_addr_onehot_o  out  Capacity  one-cycle pulse per slot released.
REQ-012 out_valid_o / out_ready_i / out_data_o (wresp_t)  out/in/out  1/1/$bits(wresp_t)  response toward requester.

Function
REQ-013 Each slot SHALL be in exactly one of FREE, RESERVED, FILLED; FREE->RESERVED on reservation, RESERVED->FILLED on response store, FILLED->FREE on release.
REQ-014 rsv_ready_o SHALL be 1 iff any slot is FREE; rsv_iid_o SHALL be the lowest-index FREE slot.
REQ-015 A reservation handshake (rsv_valid_i & rsv_ready_o) SHALL record rsv_id_i and reservation age in the granted slot.
REQ-016 Age SHALL be kept as a Capacity x Capacity age matrix; a newly reserved slot is younger than every non-FREE slot.
REQ-017 in_ready_o SHALL be 1 iff a RESERVED slot with id == in_data_i.id exists; on handshake the response is stored in the oldest such slot.
REQ-018 A response with no matching RESERVED slot SHALL be held off (in_ready_o = 0), never dropped.
REQ-019 A slot's release flag SHALL be set when release_en_i[slot] is 1 while slot is non-FREE, stay set until the slot is FREE, and ignore release_en_i for FREE slots.
REQ-020 A slot is eligible iff FILLED, release flag set (including release_en_i this cycle), and no older non-FREE slot has the same id.
REQ-021 One output register SHALL hold the response being presented; out_valid_o is its valid bit.
REQ-022 When the output register is empty or drains this cycle (out_valid_o & out_ready_i), the oldest eligible slot SHALL be loaded into it.
REQ-023 On that load, released_addr_onehot_o SHALL pulse that slot's bit for exactly that cycle; the slot becomes FREE next cycle.
REQ-024 Latency: slot FILLED and released in cycle N -> out_valid_o in cycle N+1 if output register free.
REQ-025 out_valid_o and out_data_o SHALL remain stable while out_valid_o & !out_ready_i.
REQ-026 A slot freed in cycle N SHALL NOT be granted before cycle N+1.
REQ-027 A slot reserved in cycle N SHALL NOT accept a response before cycle N+1.
REQ-028 Response store and release_en for the same slot in one cycle SHALL make it eligible that cycle.
REQ-029 With all Capacity slots non-FREE, rsv_ready_o = 0 and reservations stall without loss.

Reset
REQ-030 On rst_ni low: all slots FREE, release flags 0, age matrix cleared, output register empty.
REQ-031 Reset outputs: rsv_ready_o 1, rsv_iid_o 0, in_ready_o 0, out_valid_o 0, released_addr_onehot_o 0, out_data_o 0.
REQ-032 Reset mid-operation SHALL discard all stored responses and reservations without emitting pulses.

Structure
REQ-033 wresp_t, IDWidth, WriteRespBankCapacity, WriteRespBankAddrWidth SHALL live in simmem_pkg.
REQ-034 Per-slot state and age matrix SHALL be in this module; no sub-module other than an optional lowest-index one-hot priority encoder simmem_lzc_onehot.

Verification
REQ-035 Reserve id 3 (iid 0), response id 3, release_en[0] 2 cycles later -> out_valid_o next cycle, released_addr_onehot_o = 'b1 on the load cycle.
REQ-036 Reserve id 5 at iid 0 then iid 1, responses both arrive, release_en[1] only -> no output; add release_en[0] -> iid 0 then iid 1 out in order.
REQ-037 Reserve ids 1 (iid 0) and 2 (iid 1), release both, fill iid 1 first -> id 2 output before id 1.
REQ-038 Fill all Capacity slots -> rsv_ready_o 0; release one, drain -> rsv_ready_o 1 the cycle after the pulse, rsv_iid_o = freed index.
REQ-039 Response id 7 with no reservation -> in_ready_o 0 until id 7 reserved, then accepted next cycle.
REQ-040 out_ready_i held 0 for 5 cycles with two eligible slots -> out_data_o stable, one pulse only; assert rst_ni mid-sequence -> all outputs to reset values.
